// File: rtl/pcie_rx_drain.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pcie_rx_drain
//
// Receive-side drain. Pulls 10-bit words from four egress FIFOs (lanes 4..7),
// merges them round-robin into one valid/ready stream through a small skid
// buffer, checks each word's destination field against its source lane and
// keeps per-lane delivered-word counters that can be read while idle.
//
// Ports
//   clk, reset (sync, active-low), init (re-initialise)
//   data4_in..data7_in : FIFO read data, valid the cycle after the pop
//   empty4..empty7     : FIFO empty flags
//   pop4..pop7         : FIFO pop strobes (at most one per cycle)
//   data_out, lane_out, valid_out, ready_in : merged output stream
//   err_dest           : sticky destination-mismatch flag
//   req, idx           : counter read request / lane select (IDLE only)
//   counter_out, cnt_valid : counter read response, one cycle after req
//   idle_out           : FSM is in IDLE
// ---------------------------------------------------------------------------
module pcie_rx_drain #(
    parameter int BUF_DEPTH = 4,
    parameter int CNT_W     = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic [9:0]       data4_in,
    input  logic [9:0]       data5_in,
    input  logic [9:0]       data6_in,
    input  logic [9:0]       data7_in,
    input  logic             empty4,
    input  logic             empty5,
    input  logic             empty6,
    input  logic             empty7,
    output logic             pop4,
    output logic             pop5,
    output logic             pop6,
    output logic             pop7,
    output logic [9:0]       data_out,
    output logic [1:0]       lane_out,
    output logic             valid_out,
    input  logic             ready_in,
    output logic             err_dest,
    input  logic             req,
    input  logic [1:0]       idx,
    output logic [CNT_W-1:0] counter_out,
    output logic             cnt_valid,
    output logic             idle_out
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam logic [AW+1:0] DEPTH_L = (AW+2)'(BUF_DEPTH);

    typedef enum logic [1:0] {
        S_RESET  = 2'd0,
        S_INIT   = 2'd1,
        S_IDLE   = 2'd2,
        S_ACTIVE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // skid buffer: {lane, word} entries
    logic [11:0]      r_mem [BUF_DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_occ;

    // pop issued last cycle; its data is on the FIFO read port this cycle
    logic             r_vld_p1;
    logic [1:0]       r_lane_p1;

    logic [1:0]       r_rr;
    logic [CNT_W-1:0] r_count [4];
    logic             r_err;
    logic [CNT_W-1:0] r_cnt_out;
    logic             r_cnt_vld;

    logic [3:0]       w_empty;
    logic [9:0]       w_din [4];
    logic [9:0]       w_cap_word;
    logic             w_clear;
    logic             w_run;
    logic [AW+1:0]    w_fill;
    logic             w_room;
    logic             w_grant;
    logic [1:0]       w_glane;
    logic [1:0]       w_cand;
    logic             w_pop_any;
    logic [3:0]       w_pop;
    logic             w_enq;
    logic             w_deq;
    logic [11:0]      w_head;

    assign w_empty = {empty7, empty6, empty5, empty4};
    assign w_din[0] = data4_in;
    assign w_din[1] = data5_in;
    assign w_din[2] = data6_in;
    assign w_din[3] = data7_in;

    // Buffer, pointers and in-flight tracking are wiped on reset, in the
    // RESET state and on every INIT cycle.
    assign w_clear = !reset || (r_state == S_RESET) || (r_state == S_INIT);
    // No new pops while init is requested so nothing lands after INIT begins.
    assign w_run   = reset && !init && (r_state == S_ACTIVE);

    // Reserve a slot for the word still on its way from the FIFO.
    assign w_fill = {1'b0, r_occ} + {{(AW+1){1'b0}}, r_vld_p1};
    assign w_room = (w_fill < DEPTH_L);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RESET:  w_state_nxt = S_INIT;
            S_INIT:   w_state_nxt = init ? S_INIT : S_IDLE;
            S_IDLE: begin
                if (init)
                    w_state_nxt = S_INIT;
                else if ((w_empty != 4'hF) || (r_occ != '0))
                    w_state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (init)
                    w_state_nxt = S_INIT;
                else if ((w_empty == 4'hF) && (r_occ == '0) && !r_vld_p1)
                    w_state_nxt = S_IDLE;
            end
            default:  w_state_nxt = S_RESET;
        endcase
        if (!reset)
            w_state_nxt = S_RESET;
    end

    // ---------------- stage p0: round-robin arbitration and pop ----------------
    always_comb begin
        w_grant = 1'b0;
        w_glane = r_rr;
        w_cand  = r_rr;
        for (int i = 0; i < 4; i++) begin
            w_cand = r_rr + 2'(i);
            if (!w_grant && !w_empty[w_cand]) begin
                w_grant = 1'b1;
                w_glane = w_cand;
            end
        end
    end

    assign w_pop_any = w_run && w_room && w_grant;

    always_comb begin
        w_pop = 4'b0000;
        if (w_pop_any)
            w_pop[w_glane] = 1'b1;
    end

    assign pop4 = w_pop[0];
    assign pop5 = w_pop[1];
    assign pop6 = w_pop[2];
    assign pop7 = w_pop[3];

    // ---------------- stage p1: capture FIFO read data into the buffer ----------------
    assign w_cap_word = w_din[r_lane_p1];
    assign w_enq      = r_vld_p1;
    assign w_deq      = valid_out && ready_in;

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_vld_p1 <= 1'b0;
            r_rr     <= 2'd0;
            r_wp     <= '0;
            r_rp     <= '0;
            r_occ    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_vld_p1 <= w_pop_any;
            if (w_pop_any)
                r_rr <= w_glane + 2'd1;
            if (w_enq) begin
                r_wp <= r_wp + 1'b1;
                if (w_cap_word[9:8] != r_lane_p1)
                    r_err <= 1'b1;
            end
            if (w_deq)
                r_rp <= r_rp + 1'b1;
            case ({w_enq, w_deq})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_pop_any)
            r_lane_p1 <= w_glane;
        if (w_enq && !w_clear)
            r_mem[r_wp] <= {r_lane_p1, w_cap_word};
    end

    // ---------------- stage p2: buffer head drives the output stream ----------------
    assign w_head    = r_mem[r_rp];
    assign valid_out = (r_occ != '0) && ((r_state == S_IDLE) || (r_state == S_ACTIVE));
    assign data_out  = valid_out ? w_head[9:0]   : 10'd0;
    assign lane_out  = valid_out ? w_head[11:10] : 2'd0;
    assign err_dest  = r_err;
    assign idle_out  = (r_state == S_IDLE);

    // Delivered-word counters, wrapping at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            for (int i = 0; i < 4; i++)
                r_count[i] <= '0;
        end else if (w_deq) begin
            r_count[lane_out] <= r_count[lane_out] + 1'b1;
        end
    end

    // Counter read port: answers only requests made in IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt_out <= '0;
            r_cnt_vld <= 1'b0;
        end else if ((r_state == S_IDLE) && req) begin
            r_cnt_out <= r_count[idx];
            r_cnt_vld <= 1'b1;
        end else begin
            r_cnt_out <= '0;
            r_cnt_vld <= 1'b0;
        end
    end

    assign counter_out = r_cnt_out;
    assign cnt_valid   = r_cnt_vld;

endmodule

// File: tb/tb_pcie_rx_drain.sv
`timescale 1ns/1ps
module tb_pcie_rx_drain;

    localparam int BUF_DEPTH = 4;
    localparam int CNT_W     = 5;

    logic             clk;
    logic             reset;
    logic             init;
    logic [9:0]       din [4];
    logic [3:0]       emp;
    logic [3:0]       pops;
    logic [9:0]       data_out;
    logic [1:0]       lane_out;
    logic             valid_out;
    logic             ready_in;
    logic             err_dest;
    logic             req;
    logic [1:0]       idx;
    logic [CNT_W-1:0] counter_out;
    logic             cnt_valid;
    logic             idle_out;

    pcie_rx_drain #(.BUF_DEPTH(BUF_DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .init(init),
        .data4_in(din[0]), .data5_in(din[1]), .data6_in(din[2]), .data7_in(din[3]),
        .empty4(emp[0]), .empty5(emp[1]), .empty6(emp[2]), .empty7(emp[3]),
        .pop4(pops[0]), .pop5(pops[1]), .pop6(pops[2]), .pop7(pops[3]),
        .data_out(data_out), .lane_out(lane_out), .valid_out(valid_out),
        .ready_in(ready_in), .err_dest(err_dest), .req(req), .idx(idx),
        .counter_out(counter_out), .cnt_valid(cnt_valid), .idle_out(idle_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Egress FIFO models, pending pushes, and expected output per lane.
    logic [9:0] fq   [4][$];
    logic [9:0] pend [4][$];
    logic [9:0] expq [4][$];
    logic [4:0] mcount [4];
    bit         merr;
    bit         mon_en;
    int         seen_lanes [$];

    // per-run observation
    int npop [4];
    int pop_order [$];
    int first_pop;
    int first_vld;

    task automatic check(input bit ok, input string name, input int act, input int expv);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // FIFO read port: pop at an edge presents the word for the next cycle.
    always @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (pops[l]) begin
                check(fq[l].size() > 0, "pop_nonempty", l, 0);
                if (fq[l].size() > 0)
                    din[l] <= fq[l].pop_front();
            end
            while (pend[l].size() > 0)
                fq[l].push_back(pend[l].pop_front());
            emp[l] <= (fq[l].size() == 0);
        end
    end

    // Output monitor: scoreboard pop/compare plus stream-protocol checks.
    bit         pv, pr;
    logic [9:0] pd;
    logic [1:0] pl;
    always @(negedge clk) begin
        if (mon_en) begin
            check($countones(pops) <= 1, "pop_onehot", int'(pops), 0);
            if (pv && !pr)
                check(valid_out && data_out == pd && lane_out == pl, "bp_hold",
                      int'({valid_out, lane_out, data_out}), int'({1'b1, pl, pd}));
            if (valid_out && ready_in) begin
                if (expq[lane_out].size() == 0) begin
                    check(1'b0, "unexpected_word", int'({lane_out, data_out}), 0);
                end else begin
                    logic [9:0] e;
                    e = expq[lane_out].pop_front();
                    check(data_out == e, "data_order", int'(data_out), int'(e));
                end
                seen_lanes.push_back(int'(lane_out));
                mcount[lane_out] = mcount[lane_out] + 5'd1;
            end
            pv = valid_out; pr = ready_in; pd = data_out; pl = lane_out;
        end else begin
            pv = 1'b0;
        end
    end

    function automatic bit is_quiet();
        bit q;
        q = idle_out;
        for (int l = 0; l < 4; l++)
            if (fq[l].size() != 0 || pend[l].size() != 0 || expq[l].size() != 0)
                q = 1'b0;
        return q;
    endfunction

    task automatic push_word(input int lane, input logic [9:0] w);
        pend[lane].push_back(w);
        expq[lane].push_back(w);
        if (w[9:8] != 2'(lane))
            merr = 1'b1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic run_watch(input int bound, input string nm);
        bit done;
        done = 1'b0;
        first_pop = -1;
        first_vld = -1;
        pop_order.delete();
        for (int l = 0; l < 4; l++) npop[l] = 0;
        for (int c = 0; c < bound; c++) begin
            step();
            for (int l = 0; l < 4; l++)
                if (pops[l]) begin
                    npop[l]++;
                    pop_order.push_back(l);
                    if (first_pop < 0) first_pop = c;
                end
            if (valid_out && first_vld < 0) first_vld = c;
            if (is_quiet()) begin
                done = 1'b1;
                break;
            end
        end
        check(done, {nm, "_drain_timeout"}, int'(done), 1);
    endtask

    task automatic do_init();
        init = 1'b1;
        for (int l = 0; l < 4; l++) mcount[l] = 5'd0;
        merr = 1'b0;
        step(); step();
        init = 1'b0;
        step(); step();
    endtask

    task automatic read_cnt(input int lane, input string nm);
        req = 1'b1;
        idx = 2'(lane);
        step();
        req = 1'b0;
        check(cnt_valid == 1'b1, {nm, "_cnt_valid"}, int'(cnt_valid), 1);
        check(counter_out == mcount[lane], {nm, "_counter"}, int'(counter_out), int'(mcount[lane]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; init = 1'b0; ready_in = 1'b1; req = 1'b0; idx = 2'd0;
        mon_en = 1'b0; merr = 1'b0;
        for (int l = 0; l < 4; l++) begin
            din[l] = 10'd0;
            emp[l] = 1'b1;
            mcount[l] = 5'd0;
        end

        // ---- 1: reset and init ----
        for (int c = 0; c < 3; c++) begin
            step();
            check({pops, valid_out, data_out, lane_out, err_dest, counter_out, cnt_valid, idle_out} == '0,
                  "reset_outputs", int'({pops, valid_out, data_out, lane_out, err_dest, idle_out}), 0);
        end
        reset = 1'b1;
        init  = 1'b1;
        step(); step();
        check(idle_out == 1'b0, "init_not_idle", int'(idle_out), 0);
        init = 1'b0;
        step(); step();
        check(idle_out == 1'b1, "idle_after_init", int'(idle_out), 1);
        mon_en = 1'b1;

        // ---- 2: two words on lane 5 ----
        push_word(1, 10'h155);
        push_word(1, 10'h1AA);
        run_watch(100, "t2");
        check(npop[1] == 2 && npop[0] + npop[2] + npop[3] == 0, "t2_pops", npop[1], 2);
        check(first_vld - first_pop == 2, "t2_latency", first_vld - first_pop, 2);
        check(err_dest == 1'b0, "t2_err", int'(err_dest), 0);
        check(idle_out == 1'b1, "t2_idle", int'(idle_out), 1);

        // ---- 3: all lanes, two words each, round-robin from lane 4 ----
        do_init();
        seen_lanes.delete();
        for (int r = 0; r < 2; r++)
            for (int l = 0; l < 4; l++)
                push_word(l, {2'(l), 8'(8'h10 * r + l)});
        run_watch(200, "t3");
        check(pop_order.size() == 8, "t3_pop_count", pop_order.size(), 8);
        check(seen_lanes.size() == 8, "t3_out_count", seen_lanes.size(), 8);
        for (int i = 0; i < 8 && i < pop_order.size(); i++)
            check(pop_order[i] == i % 4, "t3_pop_order", pop_order[i], i % 4);
        for (int i = 0; i < 8 && i < seen_lanes.size(); i++)
            check(seen_lanes[i] == i % 4, "t3_lane_order", seen_lanes[i], i % 4);
        for (int l = 0; l < 4; l++) begin
            check(mcount[l] == 5'd2, "t3_model_cnt", int'(mcount[l]), 2);
            read_cnt(l, "t3");
        end

        // ---- 4: backpressure on lane 4 ----
        ready_in = 1'b0;
        for (int i = 0; i < 8; i++)
            push_word(0, 10'(10'h040 + i));
        for (int l = 0; l < 4; l++) npop[l] = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            for (int l = 0; l < 4; l++) if (pops[l]) npop[l]++;
        end
        check(npop[0] == BUF_DEPTH, "t4_pops_stalled", npop[0], BUF_DEPTH);
        check(valid_out == 1'b1, "t4_valid_held", int'(valid_out), 1);
        check(data_out == expq[0][0] && lane_out == 2'd0, "t4_head", int'(data_out), int'(expq[0][0]));
        ready_in = 1'b1;
        run_watch(200, "t4");
        check(npop[0] == 8 - BUF_DEPTH, "t4_pops_resume", npop[0], 8 - BUF_DEPTH);

        // ---- 5: destination mismatch on lane 6 ----
        seen_lanes.delete();
        push_word(2, 10'h0C3);
        run_watch(100, "t5");
        check(seen_lanes.size() == 1 && seen_lanes[0] == 2, "t5_lane", seen_lanes.size() > 0 ? seen_lanes[0] : -1, 2);
        check(err_dest == merr, "t5_err_set", int'(err_dest), int'(merr));
        step(); step(); step();
        check(err_dest == 1'b1, "t5_err_sticky", int'(err_dest), 1);
        do_init();
        check(err_dest == merr, "t5_err_cleared", int'(err_dest), int'(merr));

        // ---- 6: counter wrap on lane 7, read rules ----
        for (int i = 0; i < 33; i++)
            push_word(3, 10'(10'h300 + i));
        step(); step(); step(); step();
        check(idle_out == 1'b0, "t6_active", int'(idle_out), 0);
        req = 1'b1; idx = 2'd3;
        step();
        req = 1'b0;
        check(cnt_valid == 1'b0 && counter_out == '0, "t6_req_active", int'({cnt_valid, counter_out}), 0);
        run_watch(300, "t6");
        check(mcount[3] == 5'(33 % (1 << CNT_W)), "t6_model_wrap", int'(mcount[3]), 33 % (1 << CNT_W));
        read_cnt(3, "t6");
        step();
        check(cnt_valid == 1'b0, "t6_no_req", int'(cnt_valid), 0);

        // ---- random traffic ----
        do_init();
        for (int c = 0; c < 400; c++) begin
            ready_in = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) < 3) begin
                int l;
                logic [1:0] d;
                l = $urandom_range(0, 3);
                d = ($urandom_range(0, 9) < 8) ? 2'(l) : 2'($urandom_range(0, 3));
                push_word(l, {d, 8'($urandom_range(0, 255))});
            end
            step();
        end
        ready_in = 1'b1;
        run_watch(2000, "rnd");
        check(err_dest == merr, "rnd_err", int'(err_dest), int'(merr));
        for (int l = 0; l < 4; l++)
            read_cnt(l, "rnd");

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/pcie_rx_drain.md
Name: pcie_rx_drain

Overview:
Receive-side drain for the transaction path. It pulls words out of the four 10-bit egress FIFOs (lanes 4..7) and merges them round-robin into one handshaked output stream through an internal skid buffer. Each word's destination field is checked against the lane it came from. The block keeps per-lane delivered-word counters that can be read while idle, and it is controlled by a RESET/INIT/IDLE/ACTIVE state machine.

Parameters:
BUF_DEPTH, 4, skid buffer entries (power of 2, min 2)
CNT_W, 5, per-lane delivered counter width

Ports:
clk  in  1  clock
reset  in  1  sync active-low reset
init  in  1  re-initialise: clears buffer, counters, error
data4_in..data7_in  in  10 each  egress FIFO read data, valid the cycle after the matching pop
empty4..empty7  in  1 each  egress FIFO empty flags
pop4..pop7  out  1 each  egress FIFO pop strobes, at most one high per cycle
data_out  out  10  merged word
lane_out  out  2  source lane of data_out (0=lane4 .. 3=lane7)
valid_out  out  1  data_out/lane_out valid
ready_in  in  1  downstream accepts; transfer = valid_out & ready_in
err_dest  out  1  sticky: a word's [9:8] did not equal its lane
req  in  1  counter read request
idx  in  2  lane to read
counter_out  out  CNT_W  counter read data
cnt_valid  out  1  counter_out valid
idle_out  out  1  high in IDLE

Behaviour:
- Interface: reset is synchronous and active-low; the clock is clk. All state updates occur on posedge clk.
- Reset (reset=0): state goes to RESET. All pops=0, valid_out=0, data_out=0, lane_out=0, err_dest=0, counter_out=0, cnt_valid=0, idle_out=0. Buffer is emptied, counters are 0, RR pointer is 0, and the in-flight flag is cleared.
- FSM:
  - RESET goes to INIT when reset=1.
  - INIT stays in INIT while init=1 and goes to IDLE when init=0.
  - IDLE goes to ACTIVE if any empty flag is 0 or the buffer is non-empty.
  - ACTIVE goes to IDLE when all empty flags are 1, the buffer is empty and no pop is in flight.
  - From IDLE or ACTIVE, init=1 goes to INIT.
  - reset=0 from any state goes to RESET.
  - Undefined encodings go to RESET.
- INIT: buffer, counters, err_dest and the RR pointer are cleared every cycle. Pops and valid_out are 0.
- Pops are issued only in ACTIVE.
- Pop condition: a lane must be non-empty, and occupancy + inflight must be < BUF_DEPTH, counted before this cycle's dequeue.
- Arbitration: round-robin starting from the RR pointer. After a grant to lane k, the pointer becomes (k+1) mod 4. With no grant the pointer holds.
- Capture: a pop in cycle N captures data<lane>_in at the end of cycle N+1 into the buffer, tagged with the lane. The word is visible on data_out no earlier than cycle N+2 (2-cycle min latency).
- Buffer behaviour:
  - The buffer is FIFO-ordered.
  - data_out/lane_out show the head entry, and valid_out = buffer non-empty.
  - Enqueue and dequeue in the same cycle are allowed even when full, and occupancy is unchanged.
  - The pop condition guarantees the buffer never overflows.
- Destination check: at capture, if word[9:8] != lane, err_dest goes to 1 one cycle later and stays high until reset or INIT. The word is still forwarded unchanged.
- Counters: each transfer increments count[lane_out] by 1. Counters wrap from 2^CNT_W-1 to 0.
- Counter read: in IDLE with req=1, the next cycle gives counter_out=count[idx] and cnt_valid=1. Otherwise the next cycle gives cnt_valid=0 and counter_out=0.
- ACTIVE to IDLE with valid_out=0 is legal. valid_out is held and unchanged while ready_in=0, with no data change under backpressure.
- init asserted mid-burst: any in-flight word is discarded and not captured, and counters are cleared.

Test Plan:
1. Reset held 3 cycles, release, init=1 for 2 cycles then 0 -> all outputs 0 throughout reset; idle_out=1 two cycles after init falls.
2. Lane5 holds 0x155, 0x1AA (dest=01), ready_in=1 -> pop5 pulses twice; data_out 0x155 then 0x1AA with lane_out=1; first word appears 2 cycles after the first pop; err_dest=0; FSM returns to IDLE.
3. All four lanes non-empty, 2 words each with matching dest -> pop order 4,5,6,7,4,5,6,7; output lane_out sequence 0,1,2,3,0,1,2,3; count[i]=2 each.
4. ready_in=0, lane4 holds 8 words -> exactly BUF_DEPTH=4 pops, then pops stop; valid_out=1 with data stable; raising ready_in drains all 8 in order.
5. Lane6 word 0x0C3 (dest=00 on lane 2) -> err_dest=1 and stays high; word delivered with lane_out=2; init pulse clears err_dest to 0.
6. 33 words delivered on lane7, then in IDLE req=1, idx=3 -> next cycle counter_out=1 (wrapped), cnt_valid=1; req=1 during ACTIVE gives cnt_valid=0.
